bus_master_seq: RTL

BUS_MASTER_SEQ -- requirements
Module: bus_master_seq

---
 rtl/bus_master_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_master_seq.sv
// Bus master sequencer: writes NUM_OPS operands, issues a start command, then waits
// for the slave's done strobe (or times out) and captures the result.
module bus_master_seq #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        NUM_OPS   = 2,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [31:0]        LFSR_SEED = 32'hFFFF_FFFF,
  parameter int unsigned        TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              src_sel,
  input  logic [DATA_W-1:0] op_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_write,
  output logic              bus_start,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] result_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [31:0]         LfsrMask  = 32'h8020_0003;
  localparam logic [31:0]         Seed      = (LFSR_SEED == 32'h0) ? 32'hFFFF_FFFF : LFSR_SEED;
  localparam int unsigned         TimerW    = $clog2(TIMEOUT + 1);
  localparam logic [3:0]          LastIdx   = 4'(NUM_OPS - 1);
  localparam logic [TimerW-1:0]   TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StStart, StWait} state_e;

  state_e              state_q;
  logic [3:0]          idx_q;
  logic [TimerW-1:0]   timer_q;
  logic [31:0]         lfsr_q;
  logic                beat_lfsr_q;

  logic                accept;
  logic [31:0]         lfsr_cur;
  logic [DATA_W-1:0]   operand;
  logic [ADDR_W-1:0]   next_addr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LfsrMask : 32'h0);
  endfunction

  assign accept = bus_valid & bus_ready;

  // The following beat must already see the advanced LFSR when the current one is accepted.
  always_comb begin
    lfsr_cur = lfsr_q;
    if (state_q == StWrite && accept && beat_lfsr_q) begin
      lfsr_cur = lfsr_step(lfsr_q);
    end
    operand   = src_sel ? op_data : lfsr_cur[DATA_W-1:0];
    next_addr = BASE_ADDR + ADDR_W'(idx_q) + ADDR_W'(2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      timer_q      <= '0;
      lfsr_q       <= Seed;
      beat_lfsr_q  <= 1'b0;
      bus_valid    <= 1'b0;
      bus_write    <= 1'b0;
      bus_start    <= 1'b0;
      bus_addr     <= '0;
      bus_data     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      lfsr_q       <= lfsr_cur;
      case (state_q)
        StIdle: begin
          if (go) begin
            state_q     <= StWrite;
            idx_q       <= '0;
            bus_valid   <= 1'b1;
            bus_write   <= 1'b1;
            bus_start   <= 1'b0;
            bus_addr    <= BASE_ADDR + ADDR_W'(1);
            bus_data    <= operand;
            beat_lfsr_q <= ~src_sel;
            busy        <= 1'b1;
          end
        end
        StWrite: begin
          if (accept) begin
            if (idx_q == LastIdx) begin
              state_q     <= StStart;
              bus_start   <= 1'b1;
              bus_addr    <= BASE_ADDR;
              bus_data    <= DATA_W'(1);
              beat_lfsr_q <= 1'b0;
            end else begin
              idx_q       <= idx_q + 4'd1;
              bus_addr    <= next_addr;
              bus_data    <= operand;
              beat_lfsr_q <= ~src_sel;
            end
          end
        end
        StStart: begin
          if (accept) begin
            state_q   <= StWait;
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_start <= 1'b0;
            timer_q   <= '0;
          end
        end
        StWait: begin
          // A done strobe takes priority over an expiring timer.
          if (bus_done) begin
            state_q      <= StIdle;
            result       <= result_data;
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end else if (timer_q == TimerLast) begin
            state_q     <= StIdle;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
